lin_predict: RTL and testbench
==============================

# lin_predict

Fixed-point linear-model inference engine: consumes the weight vector produced by the gradient-descent trainer and evaluates y_cap = Σ feat[k]·wt[k] for streamed feature vectors. Sits downstream of the trainer; weights load via a write port and feature vectors arrive on a valid/ready stream. Uses one shared Q8.8 multiplier, one feature per cycle, and returns results on a valid/ready output stream.

## Interface
- N_FEAT, 4, features per vector (≥2)
- W, 16, signed data width, Q(W-FRAC).FRAC
- FRAC, 8, fractional bits
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- wt_we  in  1  weight write strobe
- wt_idx  in  $clog2(N_FEAT)  weight index
- wt_data  in  W  signed weight value
- in_valid  in  1  feature vector valid
- in_ready  out  1  engine can accept a vector
- in_feat  in  N_FEAT*W  packed features, feat[k] = in_feat[k*W +: W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  W  signed prediction
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, MAC, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, capture all features, clear acc, set k=0, go to MAC.
- MAC: each cycle acc += (feat[k]*wt[k]) >>> FRAC, then k++. After k=N_FEAT-1, go to HOLD.
- HOLD: out_valid=1, out_y stable. On out_ready, go to IDLE. Without out_ready, stay in HOLD indefinitely.
- Arithmetic:
  - Product is full 2W-bit signed.
  - Arithmetic right shift by FRAC truncates toward −∞.
  - acc is 2W-bit signed and never overflows internally.
  - out_y = acc[W-1:0] (wrap), unless saturation is compiled in.
- Weights:
  - Register file wt[0..N_FEAT-1]. Reset value is 0x0040 (0.25) for every entry, matching the trainer's initial weights.
  - wt_we takes effect only in IDLE. Writes in MAC or HOLD are dropped, so weights are constant for an in-flight vector.
  - If a write and an accept happen on the same IDLE edge, the write is applied and is used by that vector.
  - wt_idx ≥ N_FEAT is ignored.
- Reset, asynchronous, including mid-MAC or mid-HOLD:
  - State goes to IDLE; in_ready=1, out_valid=0, out_y=0, busy=0.
  - acc and k are cleared; weights return to 0x0040.
  - The in-flight vector is discarded.

## Timing
- Accept at edge T. MAC occupies edges T+1..T+N_FEAT. out_valid is high after edge T+N_FEAT.
- Result pop at edge P (out_ready high in HOLD). in_ready is high after P, so the earliest next accept is edge P+1.
- Minimum issue interval is N_FEAT+2 cycles (6 for the defaults).
- in_ready is a registered state decode with no combinational path from out_ready.
- out_y changes only on the MAC→HOLD transition.

## Configuration
- LIN_PREDICT_SAT_EN:
  - Defined: out_y saturates to 0x7FFF / 0x8000 when acc is outside the W-bit signed range. An added output sat_flag (1 bit, reset 0) is high in HOLD when clamping occurred.
  - Undefined: out_y = acc[W-1:0] and the sat_flag port does not exist.

## Structure
- Shared package lin_pkg holds:
  - W and FRAC defaults
  - WT_INIT = 16'h0040
  - the state enum type (IDLE, MAC, HOLD)
- One sub-module, fx_mul_q88: combinational signed W×W multiply returning the 2W-bit product shifted right by FRAC. Instanced once and shared across features.

## Test plan
- Default weights; features 2,4,3,6 (0x0200,0x0400,0x0300,0x0600) -> out_y=0x03C0 (3.75), out_valid 4 cycles after accept.
- Write wt=1.0 (0x0100) to all entries; features −1,2,0,0 (0xFF00,0x0200,0,0) -> out_y=0x0100.
- Truncation: wt[0]=0x0080, others 0; feat[0]=0xFFFF -> out_y=0xFFFF; feat[0]=0x0001 -> out_y=0x0000.
- Overflow: all wt=0x0100, all feat=0x7F00 -> without the macro out_y=0xFC00; with LIN_PREDICT_SAT_EN out_y=0x7FFF and sat_flag=1.
- Backpressure and write blocking: hold out_ready=0 for 10 cycles and pulse wt_we during HOLD -> out_y stable, in_ready=0, weight unchanged; then pulse out_ready -> next accept exactly 1 edge later.
- Assert RST_N low mid-MAC -> immediately out_valid=0, in_ready=1, weights=0x0040; a new vector after release yields a fresh correct result.

Source files
------------

// File: rtl/lin_pkg.sv
// Shared types and defaults for the linear-model inference engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lin_pkg;

  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;

  // Trainer's initial weight (0.25 in Q8.8); every weight returns here on reset.
  localparam logic [15:0] WT_INIT = 16'h0040;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fx_mul_q88.sv
// Signed WxW fixed-point multiply, full 2W-bit product shifted right by FRAC.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fx_mul_q88
  import lin_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [W-1:0]   i_a,
  input  logic signed [W-1:0]   i_b,
  output logic signed [2*W-1:0] o_p
);

  logic signed [2*W-1:0] w_a;
  logic signed [2*W-1:0] w_b;
  logic signed [2*W-1:0] w_full;

  // Sign-extend explicitly so the product is formed at full 2W width.
  assign w_a    = {{W{i_a[W-1]}}, i_a};
  assign w_b    = {{W{i_b[W-1]}}, i_b};
  assign w_full = w_a * w_b;

  // Arithmetic shift floors toward minus infinity, matching the trainer's rounding.
  assign o_p = w_full >>> FRAC;

endmodule

// File: rtl/lin_predict.sv
// Linear-model inference: y = sum(feat[k]*wt[k]) with one shared multiplier; optional LIN_PREDICT_SAT_EN saturates out_y.
// Latency: result valid N_FEAT cycles after the accept edge; minimum issue interval N_FEAT+2.
// Backpressure: result held in HOLD until o_out_ready; i_in_ready is a pure state decode (no path from o_out_ready).
module lin_predict
  import lin_pkg::*;
#(
  parameter int N_FEAT = 4,
  parameter int W      = W_DEF,
  parameter int FRAC   = FRAC_DEF,
  localparam int IDXW  = $clog2(N_FEAT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wt_we,
  input  logic [IDXW-1:0]     i_wt_idx,
  input  logic [W-1:0]        i_wt_data,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [N_FEAT*W-1:0] i_in_feat,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [W-1:0]        o_out_y,
`ifdef LIN_PREDICT_SAT_EN
  output logic                o_sat_flag,
`endif
  output logic                o_busy
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [W-1:0]   r_feat [N_FEAT];
  logic signed [W-1:0]   r_wt   [N_FEAT];
  logic signed [2*W-1:0] r_acc;
  logic [IDXW-1:0]       r_k;
  logic [W-1:0]          r_y;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_wt_wr;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W-1:0] w_acc_nxt;
  logic [W-1:0]          w_y_nxt;

  assign w_accept  = (r_state == IDLE) && i_in_valid;
  assign w_last    = (r_k == IDXW'(N_FEAT - 1));
  // Weights are frozen while a vector is in flight; out-of-range indices are dropped.
  assign w_wt_wr   = i_wt_we && (r_state == IDLE) &&
                     ({1'b0, i_wt_idx} < (IDXW + 1)'(N_FEAT));
  assign w_acc_nxt = r_acc + w_prod;
  assign o_out_y   = r_y;

  fx_mul_q88 #(
    .W    (W),
    .FRAC (FRAC)
  ) u_mul (
    .i_a (r_feat[r_k]),
    .i_b (r_wt[r_k]),
    .o_p (w_prod)
  );

`ifdef LIN_PREDICT_SAT_EN
  localparam logic signed [2*W-1:0] ACC_MAX = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [2*W-1:0] ACC_MIN = {{(W + 1){1'b1}}, {(W - 1){1'b0}}};
  logic w_hi;
  logic w_lo;
  logic r_sat;

  assign w_hi       = (w_acc_nxt > ACC_MAX);
  assign w_lo       = (w_acc_nxt < ACC_MIN);
  assign w_y_nxt    = w_hi ? {1'b0, {(W - 1){1'b1}}} :
                      w_lo ? {1'b1, {(W - 1){1'b0}}} : w_acc_nxt[W-1:0];
  assign o_sat_flag = r_sat;

  // Clamp indicator: latched with the result, cleared when the result is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (r_state == MAC && w_last) begin
      r_sat <= w_hi || w_lo;
    end else if (r_state == HOLD && i_out_ready) begin
      r_sat <= 1'b0;
    end
  end
`else
  assign w_y_nxt = w_acc_nxt[W-1:0];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (i_in_valid) w_state_nxt = MAC;
      end
      MAC: begin
        if (w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Weight file: a write coinciding with an accept lands before the first MAC cycle reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FEAT; i++) r_wt[i] <= W'(WT_INIT);
    end else if (w_wt_wr) begin
      r_wt[i_wt_idx] <= i_wt_data;
    end
  end

  // Datapath: capture features, accumulate one product per cycle, publish on MAC->HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FEAT; i++) r_feat[i] <= '0;
      r_acc <= '0;
      r_k   <= '0;
      r_y   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < N_FEAT; i++) r_feat[i] <= i_in_feat[i*W +: W];
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        MAC: begin
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_k <= '0;
            r_y <= w_y_nxt;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lin_predict.sv
// Directed and randomized checks of lin_predict against an arithmetic reference model.
// Latency: n/a.
// Backpressure: exercises stalled results and blocked weight writes.
`timescale 1ns/1ps
module tb_lin_predict;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wt_we;
  logic [1:0]    i_wt_idx;
  logic [15:0]   i_wt_data;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [N*16-1:0] i_in_feat;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [15:0]   o_out_y;
  logic          o_busy;
`ifdef LIN_PREDICT_SAT_EN
  logic          o_sat_flag;
`endif

  int errors = 0;
  int checks = 0;

  logic signed [15:0] m_wt [N];
  logic [15:0]        feat_q [N];
  logic               m_sat;

  lin_predict #(.N_FEAT(N), .W(16), .FRAC(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wt_we     (i_wt_we),
    .i_wt_idx    (i_wt_idx),
    .i_wt_data   (i_wt_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_feat   (i_in_feat),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_y     (o_out_y),
`ifdef LIN_PREDICT_SAT_EN
    .o_sat_flag  (o_sat_flag),
`endif
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sum of floor(feat*wt / 256) in wide integers, then wrap or clamp to 16 bits.
  function automatic logic [15:0] model_y();
    longint acc = 0;
    for (int k = 0; k < N; k++)
      acc += (longint'($signed(feat_q[k])) * longint'(m_wt[k])) >>> 8;
    m_sat = 1'b0;
`ifdef LIN_PREDICT_SAT_EN
    if (acc > 32767)  begin m_sat = 1'b1; return 16'h7FFF; end
    if (acc < -32768) begin m_sat = 1'b1; return 16'h8000; end
`endif
    return acc[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_feat(input logic [15:0] a, b, c, d);
    feat_q[0] = a; feat_q[1] = b; feat_q[2] = c; feat_q[3] = d;
    for (int k = 0; k < N; k++) i_in_feat[k*16 +: 16] = feat_q[k];
  endtask

  task automatic write_wt(input int idx, input logic [15:0] val);
    i_wt_we = 1'b1; i_wt_idx = 2'(idx); i_wt_data = val;
    tick();
    i_wt_we = 1'b0;
    m_wt[idx] = val;
  endtask

  task automatic accept();
    int guard = 0;
    while (!o_in_ready && guard < 20) begin tick(); guard++; end
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!o_out_valid && cyc < 20) begin tick(); cyc++; end
  endtask

  task automatic pop();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] exp, input int stall);
    int cyc;
    logic [15:0] dummy;
    accept();
    wait_out(cyc);
    check({tag, "_lat"}, cyc, 4);
    check({tag, "_y"}, o_out_y, exp);
`ifdef LIN_PREDICT_SAT_EN
    dummy = model_y();
    check({tag, "_sat"}, o_sat_flag, m_sat);
`else
    dummy = 16'h0;
`endif
    for (int i = 0; i < stall; i++) tick();
    pop();
    check({tag, "_popv"}, {o_out_valid, o_in_ready, dummy[0] & 1'b0}, 3'b010);
  endtask

  initial begin
    int cyc;
    logic [15:0] y_hold;
    rst_n = 1'b0; i_wt_we = 1'b0; i_wt_idx = '0; i_wt_data = '0;
    i_in_valid = 1'b0; i_in_feat = '0; i_out_ready = 1'b0;
    for (int k = 0; k < N; k++) m_wt[k] = 16'h0040;
    set_feat(0, 0, 0, 0);
    #2;
    check("rst_in_ready", o_in_ready, 1);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_out_y", o_out_y, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Default weights
    set_feat(16'h0200, 16'h0400, 16'h0300, 16'h0600);
    run_vec("dflt", 16'h03C0, 0);

    // Unit weights with a negative feature
    for (int k = 0; k < N; k++) write_wt(k, 16'h0100);
    set_feat(16'hFF00, 16'h0200, 16'h0000, 16'h0000);
    run_vec("unit", 16'h0100, 1);

    // Truncation toward minus infinity
    write_wt(0, 16'h0080);
    for (int k = 1; k < N; k++) write_wt(k, 16'h0000);
    set_feat(16'hFFFF, 0, 0, 0);
    run_vec("trunc_neg", 16'hFFFF, 0);
    set_feat(16'h0001, 0, 0, 0);
    run_vec("trunc_pos", 16'h0000, 0);

    // Overflow: wrap or clamp
    for (int k = 0; k < N; k++) write_wt(k, 16'h0100);
    set_feat(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
`ifdef LIN_PREDICT_SAT_EN
    run_vec("ovf", 16'h7FFF, 0);
`else
    run_vec("ovf", 16'hFC00, 0);
`endif

    // Write coinciding with accept is used by that vector
    set_feat(16'h0000, 16'h0100, 16'h0000, 16'h0000);
    i_wt_we = 1'b1; i_wt_idx = 2'd1; i_wt_data = 16'h0200;
    i_in_valid = 1'b1;
    tick();
    i_wt_we = 1'b0; i_in_valid = 1'b0;
    m_wt[1] = 16'h0200;
    wait_out(cyc);
    check("same_edge_lat", cyc, 4);
    check("same_edge_y", o_out_y, 16'h0200);
    pop();

    // Backpressure with blocked writes in MAC and HOLD
    set_feat(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    accept();
    i_wt_we = 1'b1; i_wt_idx = 2'd0; i_wt_data = 16'h7FFF;
    tick();
    i_wt_we = 1'b0;
    wait_out(cyc);
    check("bp_y", o_out_y, 16'h0500);
    y_hold = o_out_y;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin i_wt_we = 1'b1; i_wt_idx = 2'd2; i_wt_data = 16'h7FFF; end
      else i_wt_we = 1'b0;
      tick();
      check("bp_hold", {o_out_valid, o_in_ready, o_out_y}, {2'b10, y_hold});
    end
    i_wt_we = 1'b0;
    i_out_ready = 1'b1; i_in_valid = 1'b1;
    tick();
    i_out_ready = 1'b0;
    check("bp_pop", {o_out_valid, o_in_ready}, 2'b01);
    tick();
    i_in_valid = 1'b0;
    check("bp_next_accept", {o_busy, o_in_ready}, 2'b10);
    wait_out(cyc);
    check("bp_next_lat", cyc, 4);
    check("bp_wt_kept", o_out_y, model_y());
    pop();

    // Asynchronous reset mid-MAC
    set_feat(16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 16'(($urandom)));
    accept();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_state", {o_out_valid, o_in_ready, o_busy}, 3'b010);
    check("mrst_y", o_out_y, 0);
    for (int k = 0; k < N; k++) m_wt[k] = 16'h0040;
    @(negedge clk);
    rst_n = 1'b1;
    set_feat(16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 16'(($urandom)));
    run_vec("post_rst", model_y(), 0);

    // Randomized vectors and weight updates
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(2) == 0) write_wt($urandom_range(N - 1), 16'($urandom));
      set_feat(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_vec("rnd", model_y(), $urandom_range(3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
